// File: rtl/rssi_energy_detect.sv
// rssi_energy_detect
//
// Energy detector for calibrated RSSI samples in 0.5 dB steps. The detector
// declares the channel busy after a run of consecutive "high" samples. It
// declares the channel idle again after a run of consecutive "low" samples.
// "High" means a sample at or above th_high. "Low" means a sample below the
// lower of th_low and th_high. Samples between the two thresholds break a
// falling run, which gives hysteresis. When a busy period ends, the detector
// reports the peak RSSI and the number of valid samples in that period.
//
// Ports
//   clk                 rising-edge clock
//   rst                 synchronous active-high reset
//   enable              detector enable; low forces IDLE (reports a busy
//                       period that is in progress)
//   rssi_half_db        signed RSSI sample
//   rssi_half_db_valid  single-cycle sample strobe
//   th_high             signed busy-entry threshold
//   th_low              signed busy-exit threshold
//   rise_cnt_target     consecutive high samples needed to enter busy (0 acts as 1)
//   fall_cnt_target     consecutive low samples needed to leave busy (0 acts as 1)
//   ch_busy             registered channel-busy flag
//   busy_rise           one-cycle strobe on ch_busy 0->1
//   busy_fall           one-cycle strobe on ch_busy 1->0
//   peak_rssi_half_db   peak RSSI of the last completed busy period
//   busy_len            valid-sample count of the last completed busy period
module rssi_energy_detect #(
  parameter int RSSI_HALF_DB_WIDTH = 11,
  parameter int CNT_WIDTH          = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 enable,
  input  logic signed [RSSI_HALF_DB_WIDTH-1:0] rssi_half_db,
  input  logic                                 rssi_half_db_valid,
  input  logic signed [RSSI_HALF_DB_WIDTH-1:0] th_high,
  input  logic signed [RSSI_HALF_DB_WIDTH-1:0] th_low,
  input  logic        [3:0]                    rise_cnt_target,
  input  logic        [7:0]                    fall_cnt_target,
  output logic                                 ch_busy,
  output logic                                 busy_rise,
  output logic                                 busy_fall,
  output logic signed [RSSI_HALF_DB_WIDTH-1:0] peak_rssi_half_db,
  output logic        [CNT_WIDTH-1:0]          busy_len
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RISING  = 2'd1,
    S_BUSY    = 2'd2,
    S_FALLING = 2'd3
  } state_t;

  state_t                                state_q, state_d;
  logic        [7:0]                     run_cnt_q, run_cnt_d;
  logic signed [RSSI_HALF_DB_WIDTH-1:0]  run_peak_q, run_peak_d;
  logic        [CNT_WIDTH-1:0]           run_len_q, run_len_d;
  logic signed [RSSI_HALF_DB_WIDTH-1:0]  peak_q, peak_d;
  logic        [CNT_WIDTH-1:0]           len_q, len_d;
  logic                                  rise_q, rise_d;
  logic                                  fall_q, fall_d;

  // Sample classification
  logic signed [RSSI_HALF_DB_WIDTH-1:0]  th_low_eff;
  logic                                  sample_high;
  logic                                  sample_low;
  logic        [7:0]                     rise_tgt;
  logic        [7:0]                     fall_tgt;
  logic        [7:0]                     run_cnt_inc;
  logic signed [RSSI_HALF_DB_WIDTH-1:0]  peak_upd;
  logic        [CNT_WIDTH-1:0]           len_upd;

  // A th_low above th_high would let a sample be both high and low, so the
  // exit threshold is clamped to th_high.
  assign th_low_eff  = (th_low < th_high) ? th_low : th_high;
  assign sample_high = (rssi_half_db >= th_high);
  assign sample_low  = (rssi_half_db < th_low_eff);

  assign rise_tgt    = (rise_cnt_target == 4'd0) ? 8'd1 : {4'd0, rise_cnt_target};
  assign fall_tgt    = (fall_cnt_target == 8'd0) ? 8'd1 : fall_cnt_target;
  assign run_cnt_inc = run_cnt_q + 8'd1;

  // Running statistics after including the current sample. The length
  // counter saturates instead of wrapping.
  assign peak_upd    = (rssi_half_db > run_peak_q) ? rssi_half_db : run_peak_q;
  assign len_upd     = (&run_len_q) ? run_len_q : run_len_q + CNT_WIDTH'(1);

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      run_cnt_q  <= '0;
      run_peak_q <= '0;
      run_len_q  <= '0;
      peak_q     <= '0;
      len_q      <= '0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_cnt_q  <= run_cnt_d;
      run_peak_q <= run_peak_d;
      run_len_q  <= run_len_d;
      peak_q     <= peak_d;
      len_q      <= len_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    run_cnt_d  = run_cnt_q;
    run_peak_d = run_peak_q;
    run_len_d  = run_len_q;
    peak_d     = peak_q;
    len_d      = len_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;

    if (!enable) begin
      // Disable takes priority over any sample on the same cycle. If a busy
      // period is in progress, report it without the current sample.
      state_d   = S_IDLE;
      run_cnt_d = '0;
      if ((state_q == S_BUSY) || (state_q == S_FALLING)) begin
        fall_d = 1'b1;
        peak_d = run_peak_q;
        len_d  = run_len_q;
      end
    end else if (rssi_half_db_valid) begin
      case (state_q)
        S_IDLE: begin
          if (sample_high) begin
            if (rise_tgt <= 8'd1) begin
              state_d    = S_BUSY;
              run_cnt_d  = '0;
              run_peak_d = rssi_half_db;
              run_len_d  = CNT_WIDTH'(1);
              rise_d     = 1'b1;
            end else begin
              state_d   = S_RISING;
              run_cnt_d = 8'd1;
            end
          end
        end

        S_RISING: begin
          if (sample_high) begin
            // Use >= so that a target lowered mid-run still takes effect.
            if (run_cnt_inc >= rise_tgt) begin
              state_d    = S_BUSY;
              run_cnt_d  = '0;
              run_peak_d = rssi_half_db;
              run_len_d  = CNT_WIDTH'(1);
              rise_d     = 1'b1;
            end else begin
              run_cnt_d = run_cnt_inc;
            end
          end else begin
            state_d   = S_IDLE;
            run_cnt_d = '0;
          end
        end

        S_BUSY, S_FALLING: begin
          // Every valid sample while busy counts toward length and peak,
          // including the sample that completes the exit run.
          run_peak_d = peak_upd;
          run_len_d  = len_upd;
          if (sample_low) begin
            if (((state_q == S_BUSY) ? 8'd1 : run_cnt_inc) >= fall_tgt) begin
              state_d   = S_IDLE;
              run_cnt_d = '0;
              fall_d    = 1'b1;
              peak_d    = peak_upd;
              len_d     = len_upd;
            end else begin
              state_d   = S_FALLING;
              run_cnt_d = (state_q == S_BUSY) ? 8'd1 : run_cnt_inc;
            end
          end else begin
            state_d   = S_BUSY;
            run_cnt_d = '0;
          end
        end

        default: begin
          state_d   = S_IDLE;
          run_cnt_d = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Outputs (all decoded from registers)
  // ---------------------------------------------------------------------
  always_comb begin
    ch_busy           = (state_q == S_BUSY) || (state_q == S_FALLING);
    busy_rise         = rise_q;
    busy_fall         = fall_q;
    peak_rssi_half_db = peak_q;
    busy_len          = len_q;
  end

endmodule

// File: tb/tb_rssi_energy_detect.sv
module tb_rssi_energy_detect;

  localparam int W = 11;

  logic                clk = 1'b0;
  logic                rst;
  logic                enable;
  logic signed [W-1:0] rssi;
  logic                valid;
  logic signed [W-1:0] th_high;
  logic signed [W-1:0] th_low;
  logic [3:0]          rise_t;
  logic [7:0]          fall_t;

  logic                ch_busy, busy_rise, busy_fall;
  logic signed [W-1:0] peak;
  logic [15:0]         len;

  logic                s_ch_busy, s_rise, s_fall;
  logic signed [W-1:0] s_peak;
  logic [3:0]          s_len;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rssi_energy_detect #(.RSSI_HALF_DB_WIDTH(W), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .rssi_half_db(rssi), .rssi_half_db_valid(valid),
    .th_high(th_high), .th_low(th_low),
    .rise_cnt_target(rise_t), .fall_cnt_target(fall_t),
    .ch_busy(ch_busy), .busy_rise(busy_rise), .busy_fall(busy_fall),
    .peak_rssi_half_db(peak), .busy_len(len)
  );

  rssi_energy_detect #(.RSSI_HALF_DB_WIDTH(W), .CNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst(rst), .enable(enable),
    .rssi_half_db(rssi), .rssi_half_db_valid(valid),
    .th_high(th_high), .th_low(th_low),
    .rise_cnt_target(rise_t), .fall_cnt_target(fall_t),
    .ch_busy(s_ch_busy), .busy_rise(s_rise), .busy_fall(s_fall),
    .peak_rssi_half_db(s_peak), .busy_len(s_len)
  );

  // One valid sample followed by one idle cycle; outputs are stable at return.
  task automatic send(input int s);
    @(negedge clk);
    rssi  = W'(s);
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic cfg(input int hi, input int lo, input int r, input int f);
    th_high = W'(hi);
    th_low  = W'(lo);
    rise_t  = 4'(r);
    fall_t  = 8'(f);
  endtask

  task automatic test_reset;
    do_reset();
    vectors++; if (ch_busy !== 1'b0) begin miscompares++; $display("FAIL reset_ch_busy: got %b want 0", ch_busy); end
    vectors++; if (busy_rise !== 1'b0) begin miscompares++; $display("FAIL reset_busy_rise: got %b want 0", busy_rise); end
    vectors++; if (busy_fall !== 1'b0) begin miscompares++; $display("FAIL reset_busy_fall: got %b want 0", busy_fall); end
    vectors++; if (peak !== W'(0)) begin miscompares++; $display("FAIL reset_peak: got %0d want 0", peak); end
    vectors++; if (len !== 16'd0) begin miscompares++; $display("FAIL reset_len: got %0d want 0", len); end
    vectors++; if (s_len !== 4'd0) begin miscompares++; $display("FAIL reset_sat_len: got %0d want 0", s_len); end
    $display("test_reset done");
  endtask

  task automatic test_rise;
    int smp[4]    = '{-120, -95, -90, -85};
    logic eb[4]   = '{1'b0, 1'b0, 1'b0, 1'b1};
    cfg(-100, -110, 3, 4);
    for (int i = 0; i < 4; i++) begin
      send(smp[i]);
      $display("rise sample %0d: ch_busy=%b busy_rise=%b", smp[i], ch_busy, busy_rise);
      vectors++; if (ch_busy !== eb[i]) begin miscompares++; $display("FAIL rise_busy[%0d]: got %b want %b", i, ch_busy, eb[i]); end
      vectors++; if (busy_rise !== eb[i]) begin miscompares++; $display("FAIL rise_strobe[%0d]: got %b want %b", i, busy_rise, eb[i]); end
    end
    @(negedge clk);
    vectors++; if (busy_rise !== 1'b0) begin miscompares++; $display("FAIL rise_strobe_width: got %b want 0", busy_rise); end
    vectors++; if (ch_busy !== 1'b1) begin miscompares++; $display("FAIL rise_hold: got %b want 1", ch_busy); end
  endtask

  task automatic test_hysteresis;
    int smp[8]  = '{-105, -115, -115, -80, -120, -120, -120, -120};
    logic eb[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      send(smp[i]);
      $display("hyst sample %0d: ch_busy=%b busy_fall=%b", smp[i], ch_busy, busy_fall);
      vectors++; if (ch_busy !== eb[i]) begin miscompares++; $display("FAIL hyst_busy[%0d]: got %b want %b", i, ch_busy, eb[i]); end
      vectors++; if (busy_fall !== !eb[i]) begin miscompares++; $display("FAIL hyst_fall[%0d]: got %b want %b", i, busy_fall, !eb[i]); end
    end
    vectors++; if (len !== 16'd9) begin miscompares++; $display("FAIL hyst_len: got %0d want 9", len); end
    vectors++; if (peak !== W'(-80)) begin miscompares++; $display("FAIL hyst_peak: got %0d want -80", peak); end
    vectors++; if (busy_rise !== 1'b0) begin miscompares++; $display("FAIL hyst_no_rise: got %b want 0", busy_rise); end
    @(negedge clk);
    vectors++; if (busy_fall !== 1'b0) begin miscompares++; $display("FAIL hyst_fall_width: got %b want 0", busy_fall); end
  endtask

  task automatic test_rise_break;
    int smp[6]  = '{-90, -90, -120, -90, -90, -90};
    logic eb[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    cfg(-100, -110, 3, 4);
    for (int i = 0; i < 6; i++) begin
      send(smp[i]);
      $display("break sample %0d: ch_busy=%b", smp[i], ch_busy);
      vectors++; if (ch_busy !== eb[i]) begin miscompares++; $display("FAIL break_busy[%0d]: got %b want %b", i, ch_busy, eb[i]); end
    end
    for (int i = 0; i < 4; i++) send(-120);
    $display("break exit: ch_busy=%b len=%0d peak=%0d", ch_busy, len, peak);
    vectors++; if (ch_busy !== 1'b0) begin miscompares++; $display("FAIL break_exit: got %b want 0", ch_busy); end
    vectors++; if (len !== 16'd5) begin miscompares++; $display("FAIL break_len: got %0d want 5", len); end
    vectors++; if (peak !== W'(-90)) begin miscompares++; $display("FAIL break_peak: got %0d want -90", peak); end
  endtask

  task automatic test_th_swap;
    int smp[3]  = '{-95, -95, -101};
    logic eb[3] = '{1'b1, 1'b1, 1'b0};
    logic er[3] = '{1'b1, 1'b0, 1'b0};
    cfg(-100, -90, 0, 0);
    for (int i = 0; i < 3; i++) begin
      send(smp[i]);
      $display("swap sample %0d: ch_busy=%b rise=%b fall=%b", smp[i], ch_busy, busy_rise, busy_fall);
      vectors++; if (ch_busy !== eb[i]) begin miscompares++; $display("FAIL swap_busy[%0d]: got %b want %b", i, ch_busy, eb[i]); end
      vectors++; if (busy_rise !== er[i]) begin miscompares++; $display("FAIL swap_rise[%0d]: got %b want %b", i, busy_rise, er[i]); end
      vectors++; if (busy_fall !== !eb[i]) begin miscompares++; $display("FAIL swap_fall[%0d]: got %b want %b", i, busy_fall, !eb[i]); end
    end
    vectors++; if (len !== 16'd3) begin miscompares++; $display("FAIL swap_len: got %0d want 3", len); end
    vectors++; if (peak !== W'(-95)) begin miscompares++; $display("FAIL swap_peak: got %0d want -95", peak); end
  endtask

  task automatic test_threshold_change;
    cfg(-100, -110, 3, 1);
    send(-90);
    rise_t = 4'd2;
    send(-90);
    $display("thchg lowered rise target: ch_busy=%b", ch_busy);
    vectors++; if (ch_busy !== 1'b1) begin miscompares++; $display("FAIL thchg_enter: got %b want 1", ch_busy); end
    th_high = W'(-50);
    send(-90);
    vectors++; if (ch_busy !== 1'b1) begin miscompares++; $display("FAIL thchg_stay: got %b want 1", ch_busy); end
    th_low = W'(-80);
    send(-90);
    $display("thchg raised th_low: ch_busy=%b fall=%b len=%0d", ch_busy, busy_fall, len);
    vectors++; if (busy_fall !== 1'b1) begin miscompares++; $display("FAIL thchg_exit: got %b want 1", busy_fall); end
    vectors++; if (len !== 16'd3) begin miscompares++; $display("FAIL thchg_len: got %0d want 3", len); end
  endtask

  task automatic test_saturation;
    do_reset();
    cfg(-100, -110, 1, 1);
    for (int i = 0; i < 19; i++) send((i == 9) ? -70 : -90);
    vectors++; if (s_ch_busy !== 1'b1) begin miscompares++; $display("FAIL sat_busy: got %b want 1", s_ch_busy); end
    send(-120);
    $display("sat exit: len=%0d sat_len=%0d peak=%0d sat_fall=%b", len, s_len, s_peak, s_fall);
    vectors++; if (len !== 16'd20) begin miscompares++; $display("FAIL sat_len_wide: got %0d want 20", len); end
    vectors++; if (s_len !== 4'd15) begin miscompares++; $display("FAIL sat_len: got %0d want 15", s_len); end
    vectors++; if (s_peak !== W'(-70)) begin miscompares++; $display("FAIL sat_peak: got %0d want -70", s_peak); end
    vectors++; if (s_fall !== 1'b1) begin miscompares++; $display("FAIL sat_fall: got %b want 1", s_fall); end
  endtask

  task automatic test_enable_drop;
    cfg(-100, -110, 1, 4);
    send(-90); send(-80); send(-95);
    @(negedge clk);
    enable = 1'b0; rssi = W'(-50); valid = 1'b1;
    @(negedge clk);
    enable = 1'b1; valid = 1'b0;
    $display("endrop busy: ch_busy=%b fall=%b len=%0d peak=%0d", ch_busy, busy_fall, len, peak);
    vectors++; if (ch_busy !== 1'b0) begin miscompares++; $display("FAIL endrop_busy: got %b want 0", ch_busy); end
    vectors++; if (busy_fall !== 1'b1) begin miscompares++; $display("FAIL endrop_fall: got %b want 1", busy_fall); end
    vectors++; if (len !== 16'd3) begin miscompares++; $display("FAIL endrop_len: got %0d want 3", len); end
    vectors++; if (peak !== W'(-80)) begin miscompares++; $display("FAIL endrop_peak: got %0d want -80", peak); end
    // Disable while RISING: run is discarded, no strobe.
    rise_t = 4'd3;
    send(-90);
    @(negedge clk); enable = 1'b0;
    @(negedge clk); enable = 1'b1;
    vectors++; if ((busy_fall | busy_rise) !== 1'b0) begin miscompares++; $display("FAIL endrop_rising_strobe: got %b want 0", busy_fall | busy_rise); end
    send(-90); send(-90);
    vectors++; if (ch_busy !== 1'b0) begin miscompares++; $display("FAIL endrop_rising_cleared: got %b want 0", ch_busy); end
    send(-90);
    $display("endrop re-enter: ch_busy=%b len=%0d", ch_busy, len);
    vectors++; if (ch_busy !== 1'b1) begin miscompares++; $display("FAIL endrop_reenter: got %b want 1", ch_busy); end
    vectors++; if (len !== 16'd3) begin miscompares++; $display("FAIL endrop_len_hold: got %0d want 3", len); end
  endtask

  task automatic test_reset_mid_busy;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    $display("rst mid-busy: ch_busy=%b fall=%b len=%0d peak=%0d", ch_busy, busy_fall, len, peak);
    vectors++; if (ch_busy !== 1'b0) begin miscompares++; $display("FAIL rstbusy_busy: got %b want 0", ch_busy); end
    vectors++; if (busy_fall !== 1'b0) begin miscompares++; $display("FAIL rstbusy_fall: got %b want 0", busy_fall); end
    vectors++; if (len !== 16'd0) begin miscompares++; $display("FAIL rstbusy_len: got %0d want 0", len); end
    vectors++; if (peak !== W'(0)) begin miscompares++; $display("FAIL rstbusy_peak: got %0d want 0", peak); end
    @(negedge clk);
    vectors++; if (busy_fall !== 1'b0) begin miscompares++; $display("FAIL rstbusy_fall_after: got %b want 0", busy_fall); end
  endtask

  initial begin
    rst = 1'b0; enable = 1'b1; valid = 1'b0; rssi = '0;
    cfg(-100, -110, 3, 4);
    test_reset();
    test_rise();
    test_hysteresis();
    test_rise_break();
    test_th_swap();
    test_threshold_change();
    test_saturation();
    test_enable_drop();
    test_reset_mid_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
